lsu_unit: RTL and testbench

- Load/store unit of the RV32I core; sits directly upstream of the data memory and drives its read/write port.
- Accepts one decoded load/store from execute and checks natural alignment.
- Issues a single memory request and waits the fixed memory latency.
- Returns the sign/zero-extended load result, or a fault, to writeback with a one-cycle done pulse.

---
 rtl/memory_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 21 ++
 rtl/lsu_unit.sv | 149 ++++++++++++++
 tb/tb_lsu_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared load/store definitions: RV32I funct3 codes, memory size encoding,
// LSU state type and the funct3-to-size/store-mask helpers.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        NB_1 = 2'b00,
        NB_2 = 2'b01,
        NB_4 = 2'b10
    } n_bytes_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    function automatic n_bytes_t size_from_funct3(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return NB_1;
            2'b01:   return NB_2;
            default: return NB_4;
        endcase
    endfunction

    // Keeps only the bytes the access actually writes; the rest go out as zero.
    function automatic logic [31:0] store_mask(input n_bytes_t nb);
        case (nb)
            NB_1:    return 32'h0000_00ff;
            NB_2:    return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational sign/zero extension of right-aligned read data by load funct3.
module lsu_load_align
    import memory_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] r_data,
    output logic [31:0] data
);

    always_comb begin
        data = r_data;
        case (funct3)
            F3_LB:   data = {{24{r_data[7]}}, r_data[7:0]};
            F3_LH:   data = {{16{r_data[15]}}, r_data[15:0]};
            F3_LBU:  data = {24'd0, r_data[7:0]};
            F3_LHU:  data = {16'd0, r_data[15:0]};
            default: data = r_data;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: one operation at a time, fixed memory latency.
// Optional LSU_PERF_CNT_EN adds load/store/fault completion counters.
module lsu_unit
    import memory_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_WIDTH,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_store,
    input  logic [2:0]        op_funct3,
    input  logic [31:0]       op_addr,
    input  logic [31:0]       op_wdata,
    output logic              res_done,
    output logic [31:0]       res_data,
    output logic              res_misalign,
    output logic              res_access_err,
    output logic              mem_req,
    output logic              mem_write_en,
    output logic [1:0]        mem_n_bytes,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_w_data,
    input  logic [31:0]       mem_r_data,
    input  logic              mem_addr_err,
`ifdef LSU_PERF_CNT_EN
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_faults,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: an operation is taken on a cycle where op_valid && op_ready;
    // op_ready is high only in IDLE, so nothing is accepted while busy.

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    lsu_state_t  state, state_nx;
    logic [2:0]  cnt;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wdata_q;
    n_bytes_t    nb_q;
    logic        mis_q;
    logic        aerr_q;
    logic [31:0] data_q;
    logic [31:0] load_ext;
    logic        legal;
    logic        misalign;
    logic        fault;
    logic        sample;

    lsu_load_align u_align (
        .funct3 (f3_q),
        .r_data (mem_r_data),
        .data   (load_ext)
    );

    // Illegal encodings are folded into the misalign fault.
    always_comb begin
        legal    = 1'b0;
        misalign = 1'b0;
        if (op_store) begin
            legal = (op_funct3 == F3_SB) || (op_funct3 == F3_SH) || (op_funct3 == F3_SW);
        end else begin
            legal = (op_funct3 == F3_LB) || (op_funct3 == F3_LH) || (op_funct3 == F3_LW) ||
                    (op_funct3 == F3_LBU) || (op_funct3 == F3_LHU);
        end
        if (op_funct3[1:0] == 2'b01) misalign = op_addr[0];
        if (op_funct3[1:0] == 2'b10) misalign = (op_addr[1:0] != 2'b00);
        fault = !legal || misalign;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (op_valid) state_nx = fault ? DONE : ACCESS;
            ACCESS:  state_nx = (MEM_LAT == 1) ? DONE : WAIT;
            WAIT:    if (cnt == 3'd1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        sample = (state != IDLE) && (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            nb_q    <= NB_1;
            mis_q   <= 1'b0;
            aerr_q  <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && op_valid) begin
                st_q    <= op_store;
                f3_q    <= op_funct3;
                addr_q  <= op_addr[ADDR_W-1:0];
                wdata_q <= op_wdata & store_mask(size_from_funct3(op_funct3));
                nb_q    <= size_from_funct3(op_funct3);
                mis_q   <= fault;
                aerr_q  <= 1'b0;
                data_q  <= 32'd0;
            end
            if (state == ACCESS) cnt <= LAT_M1;
            else if (state == WAIT) cnt <= cnt - 3'd1;
            if (sample) begin
                aerr_q <= mem_addr_err;
                data_q <= (mem_addr_err || st_q) ? 32'd0 : load_ext;
            end
        end
    end

    assign op_ready       = (state == IDLE);
    assign res_done       = (state == DONE);
    assign res_data       = res_done ? data_q : 32'd0;
    assign res_misalign   = res_done & mis_q;
    assign res_access_err = res_done & aerr_q;
    assign mem_req        = (state == ACCESS);
    assign mem_write_en   = st_q;
    assign mem_n_bytes    = nb_q;
    assign mem_addr       = addr_q;
    assign mem_w_data     = wdata_q;
    assign dbg_state      = state;

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads  <= 32'd0;
            perf_stores <= 32'd0;
            perf_faults <= 32'd0;
        end else if (state == DONE) begin
            if (mis_q || aerr_q) perf_faults <= perf_faults + 32'd1;
            else if (st_q)       perf_stores <= perf_stores + 32'd1;
            else                 perf_loads  <= perf_loads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: two instances (MEM_LAT=1 and MEM_LAT=3),
// directed cases followed by random operations checked against a reference model.
module tb_lsu_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        op_valid1, op_valid3;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr, op_wdata;
    logic [31:0] mem_r_data;
    logic        mem_addr_err;

    logic        ready1, done1, mis1, acc1, req1, we1;
    logic [31:0] data1, addr1, wd1;
    logic [1:0]  nb1, st1;
    logic        ready3, done3, mis3, acc3, req3, we3;
    logic [31:0] data3, addr3, wd3;
    logic [1:0]  nb3, st3;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] pl1, ps1, pf1, pl3, ps3, pf3;
    int          m_loads[2], m_stores[2], m_faults[2];
`endif

    lsu_unit #(.ADDR_W(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(ready1),
        .op_store(op_store), .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
        .res_done(done1), .res_data(data1), .res_misalign(mis1), .res_access_err(acc1),
        .mem_req(req1), .mem_write_en(we1), .mem_n_bytes(nb1), .mem_addr(addr1),
        .mem_w_data(wd1), .mem_r_data(mem_r_data), .mem_addr_err(mem_addr_err),
`ifdef LSU_PERF_CNT_EN
        .perf_loads(pl1), .perf_stores(ps1), .perf_faults(pf1),
`endif
        .dbg_state(st1)
    );

    lsu_unit #(.ADDR_W(32), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .op_valid(op_valid3), .op_ready(ready3),
        .op_store(op_store), .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
        .res_done(done3), .res_data(data3), .res_misalign(mis3), .res_access_err(acc3),
        .mem_req(req3), .mem_write_en(we3), .mem_n_bytes(nb3), .mem_addr(addr3),
        .mem_w_data(wd3), .mem_r_data(mem_r_data), .mem_addr_err(mem_addr_err),
`ifdef LSU_PERF_CNT_EN
        .perf_loads(pl3), .perf_stores(ps3), .perf_faults(pf3),
`endif
        .dbg_state(st3)
    );

    bit sel;
    logic        o_ready, o_done, o_mis, o_acc, o_req, o_we;
    logic [31:0] o_data, o_addr, o_wd;
    logic [1:0]  o_nb, o_st;
    assign o_ready = sel ? ready3 : ready1;
    assign o_done  = sel ? done3  : done1;
    assign o_mis   = sel ? mis3   : mis1;
    assign o_acc   = sel ? acc3   : acc1;
    assign o_req   = sel ? req3   : req1;
    assign o_we    = sel ? we3    : we1;
    assign o_data  = sel ? data3  : data1;
    assign o_addr  = sel ? addr3  : addr1;
    assign o_wd    = sel ? wd3    : wd1;
    assign o_nb    = sel ? nb3    : nb1;
    assign o_st    = sel ? st3    : st1;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: result of one operation derived from the ISA rules.
    task automatic do_op(input bit s, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input bit ae);
        int          size, lat, cycles, reqs;
        bit          legal, mis, done;
        longint      v;
        logic [31:0] exp_data, exp_wd;
        logic [1:0]  exp_nb;
        lat   = s ? 3 : 1;
        size  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        legal = st ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        mis   = !legal || (addr % size != 0);
        exp_nb = (size == 1) ? 2'd0 : (size == 2) ? 2'd1 : 2'd2;
        exp_wd = 32'(longint'(wd) % (64'd1 << (8 * size)));
        case (f3)
            3'd0: begin v = rd % 256;   if (v > 127)   v -= 256;   end
            3'd1: begin v = rd % 65536; if (v > 32767) v -= 65536; end
            3'd4: v = rd % 256;
            3'd5: v = rd % 65536;
            default: v = rd;
        endcase
        exp_data = (mis || ae || st) ? 32'd0 : 32'(v);

        @(negedge clk);
        sel = s;
        op_store = st; op_funct3 = f3; op_addr = addr; op_wdata = wd;
        mem_r_data = rd; mem_addr_err = ae;
        op_valid1 = !s; op_valid3 = s;
        check("ready_idle", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        op_valid1 = 1'b0; op_valid3 = 1'b0;
        op_store = 1'($urandom); op_funct3 = 3'($urandom); op_addr = $urandom; op_wdata = $urandom;
        cycles = 0; reqs = 0; done = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (o_req) begin
                reqs++;
                check("mem_write_en", {31'd0, o_we}, {31'd0, st});
                check("mem_n_bytes", {30'd0, o_nb}, {30'd0, exp_nb});
                check("mem_addr", o_addr, addr);
                if (st) check("mem_w_data", o_wd, exp_wd);
            end
            if (o_done) begin
                done = 1;
                check("res_data", o_data, exp_data);
                check("res_misalign", {31'd0, o_mis}, {31'd0, mis});
                check("res_access_err", {31'd0, o_acc}, {31'd0, !mis && ae});
`ifdef LSU_PERF_CNT_EN
                if (mis || ae) m_faults[s]++;
                else if (st)   m_stores[s]++;
                else           m_loads[s]++;
`endif
            end else begin
                check("ready_busy", {31'd0, o_ready}, 32'd0);
                check("res_data_idle", o_data, 32'd0);
            end
        end
        check("done_latency", cycles, mis ? 32'd1 : 32'(lat + 1));
        check("req_count", reqs, mis ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        bit          rs, rst_st, rae;
        logic [2:0]  rf3;
        op_valid1 = 0; op_valid3 = 0; op_store = 0; op_funct3 = 0;
        op_addr = 0; op_wdata = 0; mem_r_data = 0; mem_addr_err = 0; sel = 0;
`ifdef LSU_PERF_CNT_EN
        m_loads = '{0, 0}; m_stores = '{0, 0}; m_faults = '{0, 0};
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, ready1}, 32'd1);
        check("rst_done", {31'd0, done1}, 32'd0);
        check("rst_req", {31'd0, req3}, 32'd0);
        check("rst_addr", addr1, 32'd0);
        check("rst_state", {30'd0, st3}, 32'd0);
        rst = 1'b0;

        do_op(0, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0);
        do_op(0, 0, 3'b000, 32'h0000_0103, 32'd0, 32'h0000_0080, 0);
        do_op(0, 0, 3'b100, 32'h0000_0103, 32'd0, 32'h0000_0080, 0);
        do_op(0, 1, 3'b001, 32'h0000_0201, 32'hAAAA_BBBB, 32'd0, 0);
        do_op(0, 1, 3'b010, 32'h0000_0204, 32'h1234_5678, 32'd0, 0);
        do_op(0, 1, 3'b000, 32'h0000_0207, 32'h1234_5678, 32'd0, 0);
        do_op(0, 0, 3'b010, 32'hFFFF_FF00, 32'd0, 32'h5555_5555, 1);
        do_op(0, 0, 3'b011, 32'h0000_0000, 32'd0, 32'h1, 0);
        do_op(1, 0, 3'b101, 32'h0000_0300, 32'd0, 32'h0000_F00D, 0);
        do_op(1, 0, 3'b001, 32'h0000_0302, 32'd0, 32'h0000_8001, 0);

        // Reset while the MEM_LAT=3 instance sits in WAIT.
        @(negedge clk);
        sel = 1;
        op_store = 0; op_funct3 = 3'b010; op_addr = 32'h400; mem_r_data = 32'h1; mem_addr_err = 0;
        op_valid3 = 1;
        @(posedge clk);
        #1 op_valid3 = 0;
        @(negedge clk);
        check("rst_test_access", {31'd0, o_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_req", {31'd0, o_req}, 32'd0);
        check("midrst_done", {31'd0, o_done}, 32'd0);
        check("midrst_ready", {31'd0, o_ready}, 32'd1);
        begin
            int dones = 0;
            repeat (5) begin
                @(negedge clk);
                if (o_done) dones++;
            end
            check("midrst_no_done", dones, 32'd0);
        end
`ifdef LSU_PERF_CNT_EN
        m_loads = '{0, 0}; m_stores = '{0, 0}; m_faults = '{0, 0};
`endif
        do_op(1, 0, 3'b010, 32'h0000_0404, 32'd0, 32'hCAFE_F00D, 0);

        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom);
            rst_st = ($urandom_range(0, 2) == 0);
            rf3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
                  (rst_st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4)));
            if (!rst_st && rf3 == 3'd3) rf3 = 3'd5;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            rae = ($urandom_range(0, 7) == 0);
            do_op(rs, rst_st, rf3, a, $urandom, $urandom, rae);
        end

`ifdef LSU_PERF_CNT_EN
        @(negedge clk);
        check("perf_loads1", pl1, m_loads[0]);
        check("perf_stores1", ps1, m_stores[0]);
        check("perf_faults1", pf1, m_faults[0]);
        check("perf_loads3", pl3, m_loads[1]);
        check("perf_stores3", ps3, m_stores[1]);
        check("perf_faults3", pf3, m_faults[1]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
